bram_ctrl: RTL and testbench



---
 rtl/mem_pkg.sv | 10 +
 rtl/bram_lane_align.sv | 30 +++
 rtl/bram_ctrl.sv | 114 +++++++++++
 tb/tb_bram_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared access-size and controller-state types for the bram front end.
//   mem_size_t        : access size encoding (3 is illegal and has no name)
//   bram_ctrl_state_t : bram_ctrl FSM states
//   WORD_BYTES, OFF_W : bytes per word and the byte-offset width
package mem_pkg;
   typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W} mem_size_t;
   typedef enum logic [1:0] {S_IDLE, S_RMW, S_RESP} bram_ctrl_state_t;
   localparam int WORD_BYTES = 4;
   localparam int OFF_W = $clog2(WORD_BYTES);
endpackage

// File: rtl/bram_lane_align.sv
// bram_lane_align: combinational load lane extract/extend and store lane merge.
//   rd_word     : word read from the bram
//   off, size   : byte offset inside the word and access size
//   is_unsigned : zero-extend loads when 1, sign-extend when 0
//   wdata       : right-aligned store data
//   ld_data     : extended load result
//   st_word     : rd_word with the addressed lane(s) replaced by wdata
module bram_lane_align
   import mem_pkg::*;
(
   input  logic [31:0]      rd_word,
   input  logic [OFF_W-1:0] off,
   input  logic [1:0]       size,
   input  logic             is_unsigned,
   input  logic [31:0]      wdata,
   output logic [31:0]      ld_data,
   output logic [31:0]      st_word
);
   logic [OFF_W+2:0] sh;
   logic [31:0]      lane;
   logic [31:0]      mask;
   always_comb begin
      sh      = {off, 3'b000};
      lane    = rd_word >> sh;
      mask    = (size == MEM_B) ? 32'h0000_00FF : (size == MEM_H) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      ld_data = (size == MEM_B) ? {{24{lane[7] & ~is_unsigned}}, lane[7:0]} :
                (size == MEM_H) ? {{16{lane[15] & ~is_unsigned}}, lane[15:0]} : rd_word;
      st_word = (rd_word & ~(mask << sh)) | ((wdata & mask) << sh);
   end
endmodule

// File: rtl/bram_ctrl.sv
// bram_ctrl: valid/ready load/store front end for a single-port bram.
//   req_*  : request port (byte address, store/load, size, extension, data)
//   resp_* : response port (extended load data, error flag)
//   mem_*  : bram port (word index, write strobe, write word, comb read word)
// Loads, word stores and errors answer one cycle after the handshake; byte and
// half stores spend one extra RMW cycle merging into the old word.
module bram_ctrl
   import mem_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int CAPACITY   = 1024,
   parameter int ADDR_WIDTH = $clog2((CAPACITY << 3) / DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [31:0]           req_addr,
   input  logic                  req_wen,
   input  logic [1:0]            req_size,
   input  logic                  req_unsigned,
   input  logic [31:0]           req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [31:0]           resp_rdata,
   output logic                  resp_err,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_wen,
   output logic [31:0]           mem_din,
   input  logic [31:0]           mem_dout
);
   bram_ctrl_state_t      state_q, state_d;
   logic [31:0]           rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [ADDR_WIDTH-1:0] idx_q, idx_d;
   logic [OFF_W-1:0]      off_q, off_d;
   logic [1:0]            size_q, size_d;
   logic [31:0]           wdata_q, wdata_d;
   logic                  rmw, hs, bad;
   logic [OFF_W-1:0]      req_off, al_off;
   logic [1:0]            al_size;
   logic [31:0]           al_wdata, ld_data, st_word;

   // In RMW the aligner works on the latched request, otherwise on the live one.
   assign rmw      = state_q == S_RMW;
   assign req_off  = req_addr[OFF_W-1:0];
   assign al_off   = rmw ? off_q : req_off;
   assign al_size  = rmw ? size_q : req_size;
   assign al_wdata = rmw ? wdata_q : req_wdata;

   bram_lane_align u_align (
      .rd_word     (mem_dout),
      .off         (al_off),
      .size        (al_size),
      .is_unsigned (req_unsigned),
      .wdata       (al_wdata),
      .ld_data     (ld_data),
      .st_word     (st_word)
   );

   always_comb begin
      hs      = req_valid && state_q == S_IDLE;
      bad     = req_size == 2'd3 || (req_size == MEM_H && req_addr[0]) ||
                (req_size == MEM_W && req_off != '0) || req_addr >= 32'(CAPACITY);
      state_d = state_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      idx_d   = idx_q;
      off_d   = off_q;
      size_d  = size_q;
      wdata_d = wdata_q;
      if (hs) begin
         state_d = (!bad && req_wen && req_size != MEM_W) ? S_RMW : S_RESP;
         err_d   = bad;
         rdata_d = (bad || req_wen) ? '0 : ld_data;
         idx_d   = req_addr[ADDR_WIDTH+1:2];
         off_d   = req_off;
         size_d  = req_size;
         wdata_d = req_wdata;
      end else if (rmw) begin
         state_d = S_RESP;
      end else if (state_q == S_RESP && resp_ready) begin
         state_d = S_IDLE;
      end
      // rst masks the strobe so a reset in RMW leaves memory untouched.
      mem_wen    = !rst && (rmw || (hs && !bad && req_wen && req_size == MEM_W));
      mem_addr   = rmw ? idx_q : req_addr[ADDR_WIDTH+1:2];
      mem_din    = st_word;
      req_ready  = state_q == S_IDLE;
      resp_valid = state_q == S_RESP;
      resp_rdata = rdata_q;
      resp_err   = err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         rdata_q <= '0;
         err_q   <= 1'b0;
         idx_q   <= '0;
         off_q   <= '0;
         size_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
         off_q   <= off_d;
         size_q  <= size_d;
         wdata_q <= wdata_d;
      end
   end
endmodule

// File: tb/tb_bram_ctrl.sv
// tb_bram_ctrl: directed self-checking bench for bram_ctrl with a behavioural bram.
module tb_bram_ctrl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [31:0] req_addr = '0;
   logic        req_wen = 1'b0;
   logic [1:0]  req_size = 2'd0;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b1;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [7:0]  mem_addr;
   logic        mem_wen;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic [31:0] mem [256];
   int          wen_cnt = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   bram_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_wen      (req_wen),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .mem_addr     (mem_addr),
      .mem_wen      (mem_wen),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout)
   );

   assign mem_dout = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_wen) begin
         mem[mem_addr] <= mem_din;
         wen_cnt <= wen_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // One complete transaction with resp_ready high; request inputs are scrambled
   // right after the handshake so late changes would be noticed.
   task automatic xfer(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output int lat, output int wens, output logic hs_wen);
      int w0;
      @(negedge clk);
      req_valid = 1'b1; req_wen = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
      resp_ready = 1'b1;
      w0 = wen_cnt;
      #1 hs_wen = mem_wen;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_addr = 32'h0000_0000; req_wdata = 32'hFFFF_FFFF; req_size = 2'd2; req_unsigned = ~u;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid && lat < 10);
      rd = resp_rdata;
      er = resp_err;
      @(posedge clk);
      #1 wens = wen_cnt - w0;
   endtask

   logic [31:0] rd;
   logic        er, hw;
   int          lat, wens, w0;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      // reset, with a word store presented that must not be written
      req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
      repeat (2) @(negedge clk);
      check("rst_mem_wen", 32'(mem_wen), 32'd0);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rdata", resp_rdata, 32'd0);
      check("rst_err", 32'(resp_err), 32'd0);
      req_valid = 1'b0;
      @(negedge clk) rst = 1'b0;
      check("rst_no_write", mem[8], 32'd0);

      xfer(1, 2, 0, 32'h10, 32'hDEADBEEF, rd, er, lat, wens, hw);
      check("wst_lat", 32'(lat), 32'd1);
      check("wst_hs_wen", 32'(hw), 32'd1);
      check("wst_wens", 32'(wens), 32'd1);
      check("wst_err", 32'(er), 32'd0);
      check("wst_rdata", rd, 32'd0);
      check("wst_mem", mem[4], 32'hDEADBEEF);

      xfer(0, 2, 0, 32'h10, 32'h0, rd, er, lat, wens, hw);
      check("wld_data", rd, 32'hDEADBEEF);
      check("wld_err", 32'(er), 32'd0);
      check("wld_lat", 32'(lat), 32'd1);
      check("wld_wens", 32'(wens), 32'd0);

      xfer(1, 0, 0, 32'h11, 32'h0000_AA55, rd, er, lat, wens, hw);
      check("bst_lat", 32'(lat), 32'd2);
      check("bst_hs_wen", 32'(hw), 32'd0);
      check("bst_wens", 32'(wens), 32'd1);
      check("bst_mem", mem[4], 32'hDEAD55EF);

      xfer(1, 1, 0, 32'h12, 32'hFFFF_1234, rd, er, lat, wens, hw);
      check("hst_lat", 32'(lat), 32'd2);
      check("hst_wens", 32'(wens), 32'd1);
      xfer(0, 2, 0, 32'h10, 32'h0, rd, er, lat, wens, hw);
      check("merge_ld", rd, 32'h123455EF);

      xfer(1, 2, 0, 32'h20, 32'h8000_0000, rd, er, lat, wens, hw);
      xfer(0, 0, 0, 32'h23, 32'h0, rd, er, lat, wens, hw);
      check("lb_signed", rd, 32'hFFFFFF80);
      xfer(0, 0, 1, 32'h23, 32'h0, rd, er, lat, wens, hw);
      check("lb_unsigned", rd, 32'h00000080);
      xfer(0, 1, 0, 32'h22, 32'h0, rd, er, lat, wens, hw);
      check("lh_signed", rd, 32'hFFFF8000);
      xfer(0, 0, 0, 32'h20, 32'h0, rd, er, lat, wens, hw);
      check("lb_off0", rd, 32'h0);
      xfer(1, 2, 0, 32'h14, 32'h0000_7F00, rd, er, lat, wens, hw);
      xfer(0, 0, 0, 32'h15, 32'h0, rd, er, lat, wens, hw);
      check("lb_pos", rd, 32'h0000007F);

      xfer(0, 1, 0, 32'h01, 32'h0, rd, er, lat, wens, hw);
      check("mis_h_err", 32'(er), 32'd1);
      check("mis_h_rdata", rd, 32'd0);
      check("mis_h_lat", 32'(lat), 32'd1);
      xfer(1, 2, 0, 32'h02, 32'h1111_1111, rd, er, lat, wens, hw);
      check("mis_w_err", 32'(er), 32'd1);
      check("mis_w_hs_wen", 32'(hw), 32'd0);
      check("mis_w_wens", 32'(wens), 32'd0);
      check("mis_w_mem", mem[0], 32'd0);
      xfer(0, 0, 0, 32'h400, 32'h0, rd, er, lat, wens, hw);
      check("oor_err", 32'(er), 32'd1);
      check("oor_rdata", rd, 32'd0);
      xfer(1, 0, 0, 32'h410, 32'h0000_0099, rd, er, lat, wens, hw);
      check("oor_st_err", 32'(er), 32'd1);
      check("oor_st_wens", 32'(wens), 32'd0);
      check("oor_st_mem", mem[4], 32'h123455EF);
      xfer(0, 3, 0, 32'h10, 32'h0, rd, er, lat, wens, hw);
      check("sz3_err", 32'(er), 32'd1);
      check("sz3_rdata", rd, 32'd0);

      xfer(1, 2, 0, 32'h3FC, 32'hA500_0000, rd, er, lat, wens, hw);
      xfer(0, 0, 1, 32'h3FF, 32'h0, rd, er, lat, wens, hw);
      check("top_err", 32'(er), 32'd0);
      check("top_data", rd, 32'h000000A5);

      // backpressure: response held for 5 cycles
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b0; req_size = 2'd2; req_addr = 32'h10; resp_ready = 1'b0;
      @(posedge clk);
      #1 req_valid = 1'b0; req_addr = 32'h20;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_valid", 32'(resp_valid), 32'd1);
         check("bp_data", resp_rdata, 32'h123455EF);
         check("bp_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1 check("bp_next_ready", 32'(req_ready), 32'd1);
      xfer(0, 2, 0, 32'h20, 32'h0, rd, er, lat, wens, hw);
      check("bp_next_ld", rd, 32'h80000000);

      // reset in the RMW cycle of a byte store
      w0 = wen_cnt;
      @(negedge clk);
      req_valid = 1'b1; req_wen = 1'b1; req_size = 2'd0; req_addr = 32'h20; req_wdata = 32'h77;
      @(posedge clk);
      #1 req_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      check("rmw_rst_wen", 32'(mem_wen), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rmw_rst_valid", 32'(resp_valid), 32'd0);
      check("rmw_rst_ready", 32'(req_ready), 32'd1);
      check("rmw_rst_mem", mem[8], 32'h80000000);
      check("rmw_rst_wens", 32'(wen_cnt - w0), 32'd0);
      xfer(0, 0, 1, 32'h20, 32'h0, rd, er, lat, wens, hw);
      check("rmw_rst_ld", rd, 32'h00000000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
